// File: rtl/vanilla_decode_queue_pkg.sv
// Shared types for the vanilla decode queue slice.
// Provides the instruction view, the integer and FP decode bundles,
// the queue state encoding and the serialising-op predicate.
package vanilla_decode_queue_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } instruction_s;

    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_MISC    = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] OP_FP      = 7'b1010011;
    localparam logic [31:0] MRET_INSTR = 32'h3020_0073;

    typedef enum logic [1:0] {eFNONE, eFADD, eFSUB, eFMUL} fpu_float_op_e;

    typedef struct packed {
        logic write_rd;
        logic read_rs1;
        logic read_rs2;
        logic is_load_op;
        logic is_store_op;
        logic is_branch_op;
        logic is_jal_op;
        logic is_jalr_op;
        logic is_csr_op;
        logic is_fence_op;
        logic is_barsend_op;
        logic is_barrecv_op;
        logic is_mret_op;
        logic is_fp_op;
        logic unsupported;
    } decode_s;

    typedef struct packed {
        logic          is_fpu_float_op;
        logic          write_frd;
        fpu_float_op_e fpu_float_op;
    } fp_decode_s;

    typedef enum logic {eNORMAL, eDRAIN} decode_queue_state_e;

    function automatic logic is_serializing(decode_s d);
        return d.is_csr_op | d.is_fence_op | d.is_barsend_op
             | d.is_barrecv_op | d.is_mret_op;
    endfunction

endpackage

// File: rtl/vanilla_decode_queue_if.sv
// Fetch/issue-side bundle for the decode queue.
//   slave  : the queue (consumes fetch + yumi, drives head outputs)
//   master : the environment (fetch and issue logic)
interface vanilla_decode_queue_if #(
    parameter int els_p      = 4,
    parameter int pc_width_p = 22
);
    import vanilla_decode_queue_pkg::*;

    logic                         flush_i;
    logic                         v_i;
    instruction_s                 instr_i;
    logic [pc_width_p-1:0]        pc_i;
    logic                         ready_o;
    logic                         v_o;
    instruction_s                 instr_o;
    logic [pc_width_p-1:0]        pc_o;
    decode_s                      decode_o;
    fp_decode_s                   fp_decode_o;
    logic                         illegal_o;
    logic [$clog2(els_p+1)-1:0]   count_o;
    logic                         yumi_i;

    modport slave (
        input  flush_i, v_i, instr_i, pc_i, yumi_i,
        output ready_o, v_o, instr_o, pc_o, decode_o, fp_decode_o, illegal_o, count_o
    );

    modport master (
        output flush_i, v_i, instr_i, pc_i, yumi_i,
        input  ready_o, v_o, instr_o, pc_o, decode_o, fp_decode_o, illegal_o, count_o
    );

endinterface

// File: rtl/vanilla_decode_queue_cl_decode.sv
// cl_decode: combinational RV32 decoder for the vanilla core subset.
//   instruction_i : raw instruction
//   decode_o      : integer-pipe control bundle (unsupported flags illegal ops)
//   fp_decode_o   : FP-pipe control bundle
module cl_decode
    import vanilla_decode_queue_pkg::*;
(
    input  instruction_s instruction_i,
    output decode_s      decode_o,
    output fp_decode_s   fp_decode_o
);
    logic rd_nz;
    assign rd_nz = |instruction_i.rd;

    always_comb begin
        decode_o    = '0;
        fp_decode_o = '0;
        case (instruction_i.op)
            OP_OP: begin
                // MUL and DIV/REM are implemented; the high-half multiplies are not.
                if ((instruction_i.funct7 == 7'b0000000) || (instruction_i.funct7 == 7'b0100000)
                    || ((instruction_i.funct7 == 7'b0000001)
                        && !(instruction_i.funct3 inside {3'b001, 3'b010, 3'b011}))) begin
                    decode_o.write_rd = rd_nz;
                    decode_o.read_rs1 = 1'b1;
                    decode_o.read_rs2 = 1'b1;
                end else begin
                    decode_o.unsupported = 1'b1;
                end
            end
            OP_IMM: begin
                decode_o.write_rd = rd_nz;
                decode_o.read_rs1 = 1'b1;
            end
            OP_LUI, OP_AUIPC: decode_o.write_rd = rd_nz;
            OP_JAL: begin
                decode_o.write_rd  = rd_nz;
                decode_o.is_jal_op = 1'b1;
            end
            OP_JALR: begin
                decode_o.write_rd   = rd_nz;
                decode_o.read_rs1   = 1'b1;
                decode_o.is_jalr_op = 1'b1;
            end
            OP_BRANCH: begin
                decode_o.read_rs1     = 1'b1;
                decode_o.read_rs2     = 1'b1;
                decode_o.is_branch_op = 1'b1;
            end
            OP_LOAD: begin
                decode_o.write_rd   = rd_nz;
                decode_o.read_rs1   = 1'b1;
                decode_o.is_load_op = 1'b1;
            end
            OP_STORE: begin
                decode_o.read_rs1    = 1'b1;
                decode_o.read_rs2    = 1'b1;
                decode_o.is_store_op = 1'b1;
            end
            OP_MISC: decode_o.is_fence_op = 1'b1;
            OP_SYSTEM: begin
                if (instruction_i.funct3 != 3'b000) begin
                    decode_o.is_csr_op = 1'b1;
                    decode_o.write_rd  = rd_nz;
                    decode_o.read_rs1  = ~instruction_i.funct3[2];
                end else if (instruction_i == MRET_INSTR) begin
                    decode_o.is_mret_op = 1'b1;
                end else begin
                    decode_o.unsupported = 1'b1;
                end
            end
            OP_CUSTOM0: begin
                if (instruction_i.funct3 == 3'b000)      decode_o.is_barsend_op = 1'b1;
                else if (instruction_i.funct3 == 3'b001) decode_o.is_barrecv_op = 1'b1;
                else                                     decode_o.unsupported   = 1'b1;
            end
            OP_FP: begin
                decode_o.is_fp_op           = 1'b1;
                decode_o.read_rs1           = 1'b1;
                decode_o.read_rs2           = 1'b1;
                fp_decode_o.is_fpu_float_op = 1'b1;
                fp_decode_o.write_frd       = 1'b1;
                case (instruction_i.funct7[6:2])
                    5'b00000: fp_decode_o.fpu_float_op = eFADD;
                    5'b00001: fp_decode_o.fpu_float_op = eFSUB;
                    5'b00010: fp_decode_o.fpu_float_op = eFMUL;
                    default: begin
                        fp_decode_o          = '0;
                        decode_o.unsupported = 1'b1;
                    end
                endcase
            end
            default: decode_o.unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/vanilla_decode_queue.sv
// vanilla_decode_queue: decode-stage circular buffer between fetch and issue.
// Instructions are decoded on enqueue so issue sees registered control.
//   clk_i, reset_i : clock, synchronous active-high reset
//   q (slave)      : fetch handshake (v_i/ready_o), flush, head outputs, yumi_i
// With serialize_p=1, a CSR/fence/barrier/MRET blocks further fetch until drained.
module vanilla_decode_queue
    import vanilla_decode_queue_pkg::*;
#(
    parameter int els_p       = 4,
    parameter int pc_width_p  = 22,
    parameter int serialize_p = 1
)(
    input  logic                  clk_i,
    input  logic                  reset_i,
    vanilla_decode_queue_if.slave q
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    typedef logic [ptr_w_lp-1:0] ptr_t;
    typedef logic [cnt_w_lp-1:0] cnt_t;

    typedef struct packed {
        instruction_s          instr;
        logic [pc_width_p-1:0] pc;
        decode_s               decode;
        fp_decode_s            fp_decode;
        logic                  ser;
    } decode_queue_entry_s;

    decode_queue_entry_s mem_r [els_p];
    decode_queue_entry_s wentry, head;
    ptr_t                wptr_r, rptr_r;
    cnt_t                count_r;
    decode_queue_state_e state_r, state_n;
    decode_s             dec;
    fp_decode_s          fp_dec;
    logic                enq, deq;

    cl_decode dec_inst (
        .instruction_i (q.instr_i),
        .decode_o      (dec),
        .fp_decode_o   (fp_dec)
    );

    // Explicit wrap so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(els_p - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        wentry           = '0;
        wentry.instr     = q.instr_i;
        wentry.pc        = q.pc_i;
        wentry.decode    = dec;
        wentry.fp_decode = fp_dec;
        wentry.ser       = is_serializing(dec);
    end

    assign head          = mem_r[rptr_r];
    assign q.ready_o     = (count_r < cnt_t'(els_p)) && (state_r == eNORMAL);
    assign q.v_o         = (count_r != '0);
    assign q.instr_o     = head.instr;
    assign q.pc_o        = head.pc;
    assign q.decode_o    = head.decode;
    assign q.fp_decode_o = head.fp_decode;
    assign q.illegal_o   = head.decode.unsupported;
    assign q.count_o     = count_r;

    assign enq = q.v_i & q.ready_o & ~q.flush_i;
    assign deq = q.yumi_i & ~q.flush_i;

    always_comb begin
        state_n = state_r;
        case (state_r)
            eNORMAL: if (enq && wentry.ser && (serialize_p != 0)) state_n = eDRAIN;
            // In DRAIN nothing is enqueued, so the serialising op is the last entry.
            eDRAIN:  if (deq && (count_r == cnt_t'(1)) && head.ser) state_n = eNORMAL;
            default: state_n = eNORMAL;
        endcase
        if (q.flush_i) state_n = eNORMAL;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            state_r <= eNORMAL;
            for (int unsigned i = 0; i < els_p; i++) mem_r[ptr_t'(i)] <= '0;
        end else begin
            state_r <= state_n;
            if (q.flush_i) begin
                wptr_r  <= '0;
                rptr_r  <= '0;
                count_r <= '0;
            end else begin
                if (enq) begin
                    mem_r[wptr_r] <= wentry;
                    wptr_r        <= ptr_inc(wptr_r);
                end
                if (deq) rptr_r <= ptr_inc(rptr_r);
                if (enq && !deq)      count_r <= count_r + cnt_t'(1);
                else if (deq && !enq) count_r <= count_r - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(q.yumi_i && !q.v_o)) else $error("decode queue: yumi_i with empty head");
            assert (count_r <= cnt_t'(els_p)) else $error("decode queue: count overflow");
        end
    end

endmodule

// File: tb/tb_vanilla_decode_queue.sv
module tb_vanilla_decode_queue;
    import vanilla_decode_queue_pkg::*;

    localparam int els_lp = 4;
    localparam int pcw_lp = 22;

    typedef struct {
        logic [31:0]       instr;
        logic [pcw_lp-1:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vanilla_decode_queue_if #(.els_p(els_lp), .pc_width_p(pcw_lp)) q1 ();
    vanilla_decode_queue_if #(.els_p(els_lp), .pc_width_p(pcw_lp)) q0 ();

    vanilla_decode_queue #(.els_p(els_lp), .pc_width_p(pcw_lp), .serialize_p(1)) dut1 (
        .clk_i (clk), .reset_i (reset), .q (q1.slave)
    );
    vanilla_decode_queue #(.els_p(els_lp), .pc_width_p(pcw_lp), .serialize_p(0)) dut0 (
        .clk_i (clk), .reset_i (reset), .q (q0.slave)
    );

    exp_t sb[$];
    bit   drain_m;
    int   vectors;
    int   miscompares;

    function automatic logic [31:0] enc_add(input logic [4:0] rd);
        return {7'b0000000, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_mulh();
        return {7'b0000001, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_csrrw();
        return {12'h300, 5'd1, 3'b001, 5'd4, 7'b1110011};
    endfunction
    function automatic logic [31:0] enc_fadd();
        return {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1010011};
    endfunction

    function automatic bit is_ser_m(input logic [31:0] ins);
        if (ins[6:0] == 7'b1110011 && ins[14:12] != 3'b000) return 1'b1;
        if (ins[6:0] == 7'b0001111) return 1'b1;
        if (ins[6:0] == 7'b0001011 && ins[14:13] == 2'b00) return 1'b1;
        if (ins == 32'h3020_0073) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock of dut1 against the scoreboard model.
    task automatic step(input string tag);
        bit   exp_ready;
        exp_t e;
        exp_ready = (sb.size() < els_lp) && !drain_m;
        check({tag, "_ready"}, 64'(q1.ready_o), 64'(exp_ready));
        check({tag, "_v"},     64'(q1.v_o),     64'(sb.size() != 0));
        check({tag, "_count"}, 64'(q1.count_o), 64'(sb.size()));
        if (reset || q1.flush_i) begin
            sb.delete();
            drain_m = 1'b0;
        end else begin
            if (q1.yumi_i && sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_pc"},    64'(q1.pc_o),    64'(e.pc));
                check({tag, "_instr"}, 64'(q1.instr_o), 64'(e.instr));
                if (drain_m && sb.size() == 0) drain_m = 1'b0;
            end
            if (q1.v_i && exp_ready) begin
                e.instr = q1.instr_i;
                e.pc    = q1.pc_i;
                sb.push_back(e);
                if (is_ser_m(q1.instr_i)) drain_m = 1'b1;
            end
        end
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0; drain_m = 1'b0;
        reset = 1'b1;
        q1.flush_i = 1'b0; q1.v_i = 1'b0; q1.instr_i = '0; q1.pc_i = '0; q1.yumi_i = 1'b0;
        q0.flush_i = 1'b0; q0.v_i = 1'b0; q0.instr_i = '0; q0.pc_i = '0; q0.yumi_i = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("reset_v",       64'(q1.v_o),       64'(0));
        check("reset_ready",   64'(q1.ready_o),   64'(1));
        check("reset_count",   64'(q1.count_o),   64'(0));
        check("reset_illegal", 64'(q1.illegal_o), 64'(0));

        // Fill to full, 5th refused, then drain in order
        for (int i = 0; i < 5; i++) begin
            q1.v_i = 1'b1; q1.instr_i = enc_add(5'd5); q1.pc_i = pcw_lp'(100 + i);
            if (i == 4) check("fill_full_ready", 64'(q1.ready_o), 64'(0));
            step("fill");
        end
        q1.v_i = 1'b0;
        check("fill_count4", 64'(q1.count_o), 64'(4));
        q1.yumi_i = 1'b1;
        repeat (4) step("drain");
        q1.yumi_i = 1'b0;
        check("drain_count0", 64'(q1.count_o), 64'(0));
        check("drain_v0",     64'(q1.v_o),     64'(0));

        // Streaming across pointer wrap
        q1.v_i = 1'b1; q1.instr_i = enc_add(5'd0); q1.pc_i = pcw_lp'(200);
        step("stream_first");
        q1.yumi_i = 1'b1;
        for (int i = 1; i < 10; i++) begin
            q1.instr_i = enc_add(5'(i)); q1.pc_i = pcw_lp'(200 + i);
            step("stream");
            check("stream_count1", 64'(q1.count_o), 64'(1));
        end
        q1.v_i = 1'b0;
        step("stream_last");
        q1.yumi_i = 1'b0;
        check("stream_count0", 64'(q1.count_o), 64'(0));

        // Serialise on CSRRW
        q1.v_i = 1'b1; q1.instr_i = enc_csrrw(); q1.pc_i = pcw_lp'(300);
        step("ser_csr");
        q1.instr_i = enc_add(5'd6); q1.pc_i = pcw_lp'(301);
        check("ser_stall_ready", 64'(q1.ready_o), 64'(0));
        step("ser_hold");
        q1.yumi_i = 1'b1;
        check("ser_stall_ready2", 64'(q1.ready_o), 64'(0));
        step("ser_deq");
        q1.yumi_i = 1'b0;
        check("ser_resume_ready", 64'(q1.ready_o), 64'(1));
        step("ser_add");
        q1.v_i = 1'b0; q1.yumi_i = 1'b1;
        step("ser_add_deq");
        q1.yumi_i = 1'b0;

        // No stall when serialize_p = 0
        q0.v_i = 1'b1; q0.instr_i = enc_csrrw(); q0.pc_i = pcw_lp'(400);
        tick();
        check("noser_ready", 64'(q0.ready_o), 64'(1));
        q0.instr_i = enc_add(5'd7); q0.pc_i = pcw_lp'(401);
        tick();
        q0.v_i = 1'b0;
        check("noser_count2", 64'(q0.count_o), 64'(2));
        q0.yumi_i = 1'b1;
        check("noser_pc0", 64'(q0.pc_o), 64'(400));
        tick();
        check("noser_pc1", 64'(q0.pc_o), 64'(401));
        tick();
        q0.yumi_i = 1'b0;
        check("noser_count0", 64'(q0.count_o), 64'(0));

        // Flush with 3 entries and simultaneous v_i/yumi_i
        q1.v_i = 1'b1; q1.instr_i = enc_add(5'd8);
        for (int i = 0; i < 3; i++) begin
            q1.pc_i = pcw_lp'(500 + i);
            step("fl_fill");
        end
        q1.yumi_i = 1'b1; q1.flush_i = 1'b1; q1.pc_i = pcw_lp'(510);
        step("fl_flush");
        q1.flush_i = 1'b0; q1.yumi_i = 1'b0; q1.v_i = 1'b0;
        check("fl_v0",     64'(q1.v_o),     64'(0));
        check("fl_count0", 64'(q1.count_o), 64'(0));
        check("fl_ready1", 64'(q1.ready_o), 64'(1));
        q1.v_i = 1'b1; q1.pc_i = pcw_lp'(520);
        step("fl_enq_after");
        q1.v_i = 1'b0; q1.yumi_i = 1'b1;
        step("fl_deq_after");
        q1.yumi_i = 1'b0;

        // Flush while draining
        q1.v_i = 1'b1; q1.instr_i = enc_csrrw(); q1.pc_i = pcw_lp'(530);
        step("fd_csr");
        q1.v_i = 1'b0;
        check("fd_ready0", 64'(q1.ready_o), 64'(0));
        q1.flush_i = 1'b1;
        step("fd_flush");
        q1.flush_i = 1'b0;
        check("fd_ready1", 64'(q1.ready_o), 64'(1));
        check("fd_v0",     64'(q1.v_o),     64'(0));

        // Reset with 2 entries in DRAIN
        q1.v_i = 1'b1; q1.instr_i = enc_add(5'd9); q1.pc_i = pcw_lp'(600);
        step("rs_add");
        q1.instr_i = enc_csrrw(); q1.pc_i = pcw_lp'(601);
        step("rs_csr");
        q1.v_i = 1'b0;
        check("rs_count2", 64'(q1.count_o), 64'(2));
        check("rs_ready0", 64'(q1.ready_o), 64'(0));
        reset = 1'b1;
        step("rs_reset");
        reset = 1'b0;
        check("rs_v0",       64'(q1.v_o),       64'(0));
        check("rs_ready1",   64'(q1.ready_o),   64'(1));
        check("rs_count0",   64'(q1.count_o),   64'(0));
        check("rs_illegal0", 64'(q1.illegal_o), 64'(0));

        // Decode fidelity
        q1.v_i = 1'b1;
        q1.instr_i = enc_mulh();      q1.pc_i = pcw_lp'(700); step("dec_mulh");
        q1.instr_i = enc_add(5'd0);   q1.pc_i = pcw_lp'(701); step("dec_addx0");
        q1.instr_i = enc_fadd();      q1.pc_i = pcw_lp'(702); step("dec_fadd");
        q1.instr_i = enc_add(5'd5);   q1.pc_i = pcw_lp'(703); step("dec_addx5");
        q1.v_i = 1'b0;
        check("dec_mulh_illegal", 64'(q1.illegal_o), 64'(1));
        q1.yumi_i = 1'b1; step("dec_pop1"); q1.yumi_i = 1'b0;
        check("dec_addx0_write_rd", 64'(q1.decode_o.write_rd), 64'(0));
        check("dec_addx0_illegal",  64'(q1.illegal_o),         64'(0));
        q1.yumi_i = 1'b1; step("dec_pop2"); q1.yumi_i = 1'b0;
        check("dec_fadd_op",    64'(q1.fp_decode_o.fpu_float_op), 64'(eFADD));
        check("dec_fadd_is_fp", 64'(q1.decode_o.is_fp_op),        64'(1));
        q1.yumi_i = 1'b1; step("dec_pop3"); q1.yumi_i = 1'b0;
        check("dec_addx5_write_rd", 64'(q1.decode_o.write_rd), 64'(1));
        q1.yumi_i = 1'b1; step("dec_pop4"); q1.yumi_i = 1'b0;
        check("dec_empty", 64'(q1.v_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vanilla_decode_queue.md
# vanilla_decode_queue

Parametrised decode-stage buffer between instruction fetch and the vanilla core's issue logic. Every accepted instruction is decoded at enqueue time with `cl_decode`; the instruction, PC and both decode bundles are stored in a circular queue of `els_p` entries. Downstream therefore sees fully registered control signals. An optional serialising mode blocks fetch behind CSR, fence, barrier and MRET instructions until they drain.

## Interface
- `els_p`, 4: queue depth; any integer ≥ 2.
- `pc_width_p`, 22: PC field width.
- `serialize_p`, 1: when 1, enables drain-on-serialising-op behaviour; when 0, the queue never enters `eDRAIN`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset; synchronous, active-high.
- `flush_i` in 1: discard all entries (redirect or exception).
- `v_i` in 1: fetch presents an instruction.
- `instr_i` in 32: instruction (`instruction_s`).
- `pc_i` in `pc_width_p`: PC of `instr_i`.
- `ready_o` out 1: queue accepts this cycle.
- `v_o` out 1: head entry valid.
- `instr_o` out 32: head instruction.
- `pc_o` out `pc_width_p`: head PC.
- `decode_o` out `decode_s`: head decode.
- `fp_decode_o` out `fp_decode_s`: head FP decode.
- `illegal_o` out 1: head `decode_o.unsupported`; duplicate for trap logic.
- `count_o` out `$clog2(els_p+1)`: occupancy.
- `yumi_i` in 1: consumer dequeues the head; legal only when `v_o` = 1.

## Operation
- Enqueue happens when `v_i & ready_o & ~flush_i`. The entry written at `wptr` holds `{instr_i, pc_i, decode, fp_decode, ser}`.
  - `ser` = `is_csr_op | is_fence_op | is_barsend_op | is_barrecv_op | is_mret_op`.
- Dequeue happens when `yumi_i & ~flush_i` and advances `rptr`.
- Pointers are `$clog2(els_p)` bits wide. Each wraps from `els_p-1` to 0 by explicit compare, not power-of-two truncation.
- `count` is +1 on enqueue only, -1 on dequeue only, and unchanged on both or neither.
- `v_o = (count != 0)`. Head outputs are read from storage at `rptr`; when `v_o` = 0 their value is don't-care.
- `ready_o = (count < els_p) & (state == eNORMAL)`. There is no enqueue-while-full even with a simultaneous dequeue, so `ready_o` has no combinational path from `yumi_i`.
- State machine (`serialize_p`=1):
  - `eNORMAL` → `eDRAIN` when an enqueue with `ser`=1 is accepted.
  - `eDRAIN` → `eNORMAL` when a dequeue occurs with `count == 1`, i.e. the serialising entry leaves. It is always youngest, since no enqueue occurs in `eDRAIN`.
  - Any state → `eNORMAL` on `flush_i`.
- Flush has priority over everything. Next cycle: `count`=0, `rptr`=`wptr`=0, `eNORMAL`. Same-cycle `v_i` and `yumi_i` are ignored.
- Reset gives the same state as flush: `v_o`=0, `ready_o`=1, `count_o`=0, `illegal_o`=0 (head storage cleared to 0 on reset only).
- An unsupported instruction is enqueued normally; only `illegal_o` flags it.
- Assertions:
  - `yumi_i & ~v_o` is an error.
  - `count` never exceeds `els_p`.

## Timing
- Enqueue to `v_o` takes 1 cycle minimum; there is no bypass.
- Throughput is 1 enq + 1 deq per cycle when neither full nor draining.
- `ready_o` depends only on registered state.
- `eDRAIN` costs at least 1 bubble: `ready_o` returns the cycle after the serialising entry is dequeued.
- Flush asserted in cycle t gives `v_o`=0 in cycle t+1. An enqueue is possible at t+1.

## Structure
- Add to `bsg_vanilla_pkg`:
  - `decode_queue_state_e {eNORMAL, eDRAIN}`.
  - `decode_queue_entry_s {instruction_s instr; logic [pc_width_p-1:0] pc; decode_s decode; fp_decode_s fp_decode; logic ser}`. Because `pc_width_p` is a parameter, this struct is declared locally in the module.
- One `cl_decode` instance sits on the enqueue path. Storage is a flop array of `els_p` entries, not a sub-module.

## Test plan
- **Fill/drain:** `els_p`=4, enqueue 5 back-to-back ADDs with `yumi_i`=0. The 5th is refused (`ready_o`=0 after 4), `count_o`=4. Dequeue all; PCs come out in order and `count_o` returns to 0.
- **Streaming wrap:** continuous `v_i` and `yumi_i` for 10 instructions. `count_o` holds 1 and the pointers wrap twice with no loss or duplication.
- **Serialise:** enqueue CSRRW then ADD. `ready_o`=0 from the cycle after CSRRW's acceptance until the cycle after its dequeue; the ADD is held by fetch. Repeat with `serialize_p`=0: there is no stall.
- **Flush:**
  - With 3 entries plus simultaneous `v_i`/`yumi_i`, assert `flush_i`. Next cycle `v_o`=0, `count_o`=0, and nothing is enqueued.
  - A flush during `eDRAIN` returns `ready_o`=1.
- **Reset mid-operation:** `reset_i` with 2 entries in `eDRAIN` gives `v_o`=0, `ready_o`=1, `count_o`=0 next cycle.
- **Decode fidelity:**
  - MULH gives `illegal_o`=1.
  - ADD with rd=x0 gives `decode_o.write_rd`=0.
  - FADD.S gives `fp_decode_o.fpu_float_op`=`eFADD`.
